round_sat_pipe: RTL and testbench
=================================

Name: round_sat_pipe

Overview:
- Multi-channel, pipelined round-and-saturate stage for the SDFT datapath.
- Drops DROP LSBs with rounding, then saturates the signed result from IW to OW bits.
- Per-channel sat flags, sticky alarms and a saturation event counter feed status/debug.
- Sits between accumulator/twiddle-multiply outputs and narrower bin storage; valid/ready on both sides.

Parameters:
- CH, 2: number of parallel channels, each processed identically.
- IW, 10: signed input width per channel.
- OW, 8: signed output width per channel. Legal range is 2 <= OW <= IW-DROP+1.
- DROP, 1: LSBs removed by rounding. DROP=0 disables rounding (pure saturation).
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- x_i  in  CH*IW  packed signed inputs; channel k at [k*IW +: IW].
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat.
- y_o  out  CH*OW  packed signed outputs; channel k at [k*OW +: OW].
- sat_o  out  CH  per-channel "this beat saturated", aligned with y_o.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- alarm_o  out  CH  sticky per-channel saturation alarms.
- alarm_clr_i  in  1  clears all sticky alarms.
- sat_cnt_o  out  CNT_W  count of accepted output beats with any sat_o bit set.
- cnt_clr_i  in  1  clears sat_cnt_o.

Behaviour:
- Reset: valid_o, y_o, sat_o, alarm_o and sat_cnt_o are all 0. The internal stage-1 valid is 0.
- Transfers occur when valid&&ready on either side.
- Stage 1 (round):
  - r = (sext(x, IW+1) + bias) >>> DROP, giving IW-DROP+1 bits. The extra bit prevents overflow, e.g. 511+1.
  - Default bias = 1<<(DROP-1) (round half up, toward +inf).
  - DROP=0: r = x.
- Stage 2 (saturate):
  - If r > 2^(OW-1)-1, then y = 2^(OW-1)-1.
  - If r < -2^(OW-1), then y = -2^(OW-1).
  - Otherwise y = r[OW-1:0].
  - sat_o[k] = 1 when clamped.
- Latency is 2 cycles from input handshake to valid_o with ready_i held high. Throughput is 1 beat/clk.
- Stall/backpressure logic:
  - s2_adv = !valid_o || ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - ready_o = s1_adv, combinational from ready_i; no skid buffer.
- While valid_o=1 and ready_i=0, y_o and sat_o hold stable. No beat is lost or duplicated.
- alarm_o[k] sets on an output handshake with sat_o[k]=1. It clears on alarm_clr_i. Set and clear in the same cycle: set wins.
- sat_cnt_o increments on an output handshake with |sat_o:
  - Saturates at all-ones; no wrap.
  - cnt_clr_i has priority over increment; clear plus event in the same cycle gives 0.
- Reset asserted mid-operation: the pipeline empties immediately. Beats in flight are discarded.

Optional Feature:
- Macro ROUND_SAT_CONVERGENT_EN.
- Defined: round half to even. bias = (1<<(DROP-1)) - 1 + x[DROP], so exact ties go to the even result; non-ties are unchanged.
- Undefined: round half up as above.
- No effect when DROP=0.

Decomposition:
- Package round_sat_pkg holds:
  - localparam helpers RW(IW,DROP) = IW-DROP+1, and signed max/min constants for OW.
  - Typedef for the per-beat status struct {sat, valid}.
- Sub-module round_sat_lane: per-channel combinational round + clamp with output y and sat flag. It is instantiated CH times in a generate loop; pipeline registers stay in the top module.

Test Plan (CH=2, IW=10, OW=8, DROP=1, ready_i=1 unless noted):
- Basic: x=(3,5) -> after 2 clks y=(2,3), sat_o=00. With ROUND_SAT_CONVERGENT_EN: y=(2,2).
- Negative ties: x=(-3,-1) -> y=(-1,0). With ROUND_SAT_CONVERGENT_EN: y=(-2,0).
- Saturation: x=(300,-300) -> y=(127,-128), sat_o=11, alarm_o=11, sat_cnt_o=1. x=(511,-512) -> y=(127,-128); the 511+1 case must not overflow.
- Backpressure: stream 6 beats, drop ready_i for 3 clks mid-stream -> ready_o falls within the same cycle. y_o is held, and all 6 beats emerge in order exactly once.
- Counter/alarm: force saturating beats to sat_cnt_o max with CNT_W=4 -> holds at 15. Assert cnt_clr_i together with a sat event -> 0. Assert alarm_clr_i together with a sat beat -> alarm stays 1.
- Reset: assert rst_n_i low with 2 beats in flight -> valid_o=0, all outputs 0 immediately; after release the first new beat appears 2 clks after acceptance.

Source files
------------

// File: rtl/round_sat_pkg.sv
// Shared helpers for the round-and-saturate pipeline: width arithmetic,
// signed clamp limits and the per-beat status record.
package round_sat_pkg;

  // Width of the rounded intermediate: one guard bit above IW-DROP.
  function automatic int rw_of(input int iw, input int drop);
    return iw - drop + 1;
  endfunction

  // Largest signed value representable in ow bits.
  function automatic int smax_of(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

  // Smallest signed value representable in ow bits.
  function automatic int smin_of(input int ow);
    return -(1 << (ow - 1));
  endfunction

  // Summary of the beat held in the output stage.
  typedef struct packed {
    logic sat;
    logic valid;
  } beat_status_t;

endpackage

// File: rtl/round_sat_lane.sv
// One channel of round + clamp, purely combinational. The rounding half
// feeds the stage-1 register in the top; the clamp half reads it back.
// Optional: define ROUND_SAT_CONVERGENT_EN for round-half-to-even.
module round_sat_lane
  import round_sat_pkg::*;
#(
  parameter int IW   = 10,
  parameter int OW   = 8,
  parameter int DROP = 1,
  localparam int RW  = rw_of(IW, DROP)
) (
  input  logic [IW-1:0] x,
  output logic [RW-1:0] r,
  input  logic [RW-1:0] r_q,
  output logic [OW-1:0] y,
  output logic          sat
);

  localparam logic signed [RW-1:0] MAXV = RW'(smax_of(OW));
  localparam logic signed [RW-1:0] MINV = RW'(smin_of(OW));

  generate
    if (DROP == 0) begin : g_nodrop
      // No rounding: just sign-extend into the guard bit.
      always_comb r = {x[IW-1], x};
    end else begin : g_drop
      logic signed [IW:0] xe;
      logic signed [IW:0] bias;
      logic signed [IW:0] sum;
      // Add the rounding bias one bit wider than x, then drop the LSBs.
      always_comb begin
        xe = {x[IW-1], x};
`ifdef ROUND_SAT_CONVERGENT_EN
        bias = (IW+1)'((1 << (DROP - 1)) - 1) + (IW+1)'(x[DROP]);
`else
        bias = (IW+1)'(1 << (DROP - 1));
`endif
        sum  = xe + bias;
        r    = sum[IW:DROP];
      end
    end
  endgenerate

  // Clamp the registered rounded value into OW signed bits.
  always_comb begin
    sat = 1'b0;
    y   = r_q[OW-1:0];
    if ($signed(r_q) > MAXV) begin
      sat = 1'b1;
      y   = {1'b0, {(OW-1){1'b1}}};
    end else if ($signed(r_q) < MINV) begin
      sat = 1'b1;
      y   = {1'b1, {(OW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage multi-channel round-and-saturate pipeline with valid/ready
// on both sides, sticky per-channel alarms and a saturating event counter.
// Optional: ROUND_SAT_CONVERGENT_EN selects round-half-to-even in the lanes.
module round_sat_pipe
  import round_sat_pkg::*;
#(
  parameter int CH    = 2,
  parameter int IW    = 10,
  parameter int OW    = 8,
  parameter int DROP  = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CH*IW-1:0]    x_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [CH*OW-1:0]    y_o,
  output logic [CH-1:0]       sat_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [CH-1:0]       alarm_o,
  input  logic                alarm_clr_i,
  output logic [CNT_W-1:0]    sat_cnt_o,
  input  logic                cnt_clr_i
);

  localparam int RW = rw_of(IW, DROP);

  logic                s1_valid;
  logic [CH*RW-1:0]    r_d;
  logic [CH*RW-1:0]    r_q;
  logic [CH*OW-1:0]    y_d;
  logic [CH-1:0]       sat_d;
  logic                s1_adv;
  logic                s2_adv;
  logic                out_hs;
  beat_status_t        s2_st;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    round_sat_lane #(
      .IW   (IW),
      .OW   (OW),
      .DROP (DROP)
    ) u_lane (
      .x   (x_i[k*IW +: IW]),
      .r   (r_d[k*RW +: RW]),
      .r_q (r_q[k*RW +: RW]),
      .y   (y_d[k*OW +: OW]),
      .sat (sat_d[k])
    );
  end

  // Advance conditions ripple back from the output; no skid buffer.
  always_comb begin
    s2_adv      = !valid_o || ready_i;
    s1_adv      = !s1_valid || s2_adv;
    ready_o     = s1_adv;
    s2_st.valid = valid_o;
    s2_st.sat   = |sat_o;
    out_hs      = s2_st.valid && ready_i;
  end

  // Stage 1: capture the rounded value of each channel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      r_q      <= '0;
    end else if (s1_adv) begin
      s1_valid <= valid_i;
      if (valid_i) r_q <= r_d;
    end
  end

  // Stage 2: capture the clamped result; holds while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      y_o     <= '0;
      sat_o   <= '0;
    end else if (s2_adv) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        y_o   <= y_d;
        sat_o <= sat_d;
      end
    end
  end

  // Sticky alarms: a saturating handshake overrides a concurrent clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alarm_o <= '0;
    end else begin
      alarm_o <= (alarm_clr_i ? '0 : alarm_o) | (out_hs ? sat_o : '0);
    end
  end

  // Saturation event counter: clear wins, sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      sat_cnt_o <= '0;
    end else if (out_hs && s2_st.sat && (sat_cnt_o != '1)) begin
      sat_cnt_o <= sat_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Self-checking bench for round_sat_pipe (CH=2, IW=10, OW=8, DROP=1, CNT_W=4).
module tb_round_sat_pipe;

  localparam int CH    = 2;
  localparam int IW    = 10;
  localparam int OW    = 8;
  localparam int DROP  = 1;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*IW-1:0]    x_i;
  logic                valid_i;
  logic                ready_o;
  logic [CH*OW-1:0]    y_o;
  logic [CH-1:0]       sat_o;
  logic                valid_o;
  logic                ready_i;
  logic [CH-1:0]       alarm_o;
  logic                alarm_clr;
  logic [CNT_W-1:0]    sat_cnt_o;
  logic                cnt_clr;

  always #5 clk = ~clk;

  round_sat_pipe #(
    .CH    (CH),
    .IW    (IW),
    .OW    (OW),
    .DROP  (DROP),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .x_i         (x_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .y_o         (y_o),
    .sat_o       (sat_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .alarm_o     (alarm_o),
    .alarm_clr_i (alarm_clr),
    .sat_cnt_o   (sat_cnt_o),
    .cnt_clr_i   (cnt_clr)
  );

  typedef struct packed {
    logic [15:0] y;
    logic [1:0]  sat;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  int          exp_cnt = 0;
  logic [1:0]  exp_alarm = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rounded value of x/2 as a real-number rule.
  function automatic int round_ref(input int x);
`ifdef ROUND_SAT_CONVERGENT_EN
    int lo;
    lo = x >>> 1;
    if ((x & 1) != 0) return ((lo & 1) == 0) ? lo : lo + 1;
    return lo;
`else
    return (x + 1) >>> 1;
`endif
  endfunction

  function automatic exp_t model(input int x0, input int x1);
    exp_t e;
    int   xs[2];
    int   r;
    xs[0] = x0;
    xs[1] = x1;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      r = round_ref(xs[k]);
      if (r > 127) begin
        r = 127;
        e.sat[k] = 1'b1;
      end else if (r < -128) begin
        r = -128;
        e.sat[k] = 1'b1;
      end
      e.y[k*8 +: 8] = 8'(r);
    end
    return e;
  endfunction

  // Scoreboard and status model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [1:0] hs_sat;
    hs_sat = '0;
    if (!rst_n) begin
      q.delete();
      exp_cnt   = 0;
      exp_alarm = '0;
    end else begin
      check("alarm", 32'(alarm_o), 32'(exp_alarm));
      check("cnt", 32'(sat_cnt_o), exp_cnt);
      if (valid_o) begin
        if (q.size() == 0) begin
          check("spurious_valid", 32'(valid_o), 0);
        end else begin
          check("y", 32'(y_o), 32'(q[0].y));
          check("sat", 32'(sat_o), 32'(q[0].sat));
          if (ready_i) begin
            hs_sat = q[0].sat;
            void'(q.pop_front());
            pops++;
          end
        end
      end
      exp_alarm = (alarm_clr ? 2'b00 : exp_alarm) | hs_sat;
      if (cnt_clr) exp_cnt = 0;
      else if ((|hs_sat) && exp_cnt < 15) exp_cnt++;
      if (valid_i && ready_o)
        q.push_back(model($signed(x_i[9:0]), $signed(x_i[19:10])));
    end
  end

  // Present a beat and hold it until accepted; leaves valid_i high.
  task automatic put(input int a, input int b);
    int n;
    n = 0;
    x_i     = {10'(b), 10'(a)};
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("accept_timeout", 32'(ready_o), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    int acc;
    exp_t e;
    rst_n     = 1'b0;
    x_i       = '0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    alarm_clr = 1'b0;
    cnt_clr   = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_y", 32'(y_o), 0);
    check("rst_sat", 32'(sat_o), 0);
    check("rst_alarm", 32'(alarm_o), 0);
    check("rst_cnt", 32'(sat_cnt_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic rounding with latency check
    put(3, 5);
    valid_i = 1'b0;
    check("basic_lat1", 32'(valid_o), 0);
    @(posedge clk); #1;
    check("basic_lat2", 32'(valid_o), 1);
`ifdef ROUND_SAT_CONVERGENT_EN
    check("basic_y", 32'(y_o), 32'h0202);
`else
    check("basic_y", 32'(y_o), 32'h0302);
`endif
    check("basic_sat", 32'(sat_o), 0);
    drain();

    // Negative ties
    put(-3, -1);
    valid_i = 1'b0;
    @(posedge clk); #1;
`ifdef ROUND_SAT_CONVERGENT_EN
    check("neg_y", 32'(y_o), 32'h00fe);
`else
    check("neg_y", 32'(y_o), 32'h00ff);
`endif
    drain();

    // Saturation both directions
    put(300, -300);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("sat_y", 32'(y_o), 32'h807f);
    check("sat_flags", 32'(sat_o), 3);
    drain();
    check("sat_alarm", 32'(alarm_o), 3);
    check("sat_cnt1", 32'(sat_cnt_o), 1);

    // Extremes: 511 rounds up without wrapping
    put(511, -512);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("ext_y", 32'(y_o), 32'h807f);
    check("ext_sat", 32'(sat_o), 3);
    drain();

    // Backpressure: six beats, ready_i low for three cycles
    pops0 = pops;
    acc   = 0;
    for (int c = 0; c < 30; c++) begin
      ready_i = !(c >= 3 && c <= 5);
      valid_i = (acc < 6);
      x_i     = {10'(300 - 120 * acc), 10'(40 * acc - 100)};
      @(negedge clk);
      if (c == 3) check("bp_ready_low", 32'(ready_o), 0);
      if (c == 3) check("bp_valid_held", 32'(valid_o), 1);
      if (c == 6) check("bp_ready_high", 32'(ready_o), 1);
      if (valid_i && ready_o) acc++;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();
    check("bp_count", pops - pops0, 6);

    // Counter saturates at 15
    for (int i = 0; i < 20; i++) put(300, -300);
    valid_i = 1'b0;
    drain();
    check("cnt_max", 32'(sat_cnt_o), 15);

    // Clears concurrent with a saturating handshake
    put(-300, 300);
    valid_i = 1'b0;
    @(posedge clk); #1;
    cnt_clr   = 1'b1;
    alarm_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr   = 1'b0;
    alarm_clr = 1'b0;
    check("clr_cnt", 32'(sat_cnt_o), 0);
    check("clr_alarm_set_wins", 32'(alarm_o), 3);
    alarm_clr = 1'b1;
    @(posedge clk); #1;
    alarm_clr = 1'b0;
    check("alarm_cleared", 32'(alarm_o), 0);

    // Random traffic with random stalls and clears
    pops0 = pops;
    for (int c = 0; c < 400; c++) begin
      valid_i   = ($urandom % 4) != 0;
      ready_i   = ($urandom % 4) != 0;
      x_i       = 20'($urandom);
      cnt_clr   = ($urandom % 32) == 0;
      alarm_clr = ($urandom % 32) == 0;
      @(posedge clk); #1;
    end
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    cnt_clr   = 1'b0;
    alarm_clr = 1'b0;
    drain();

    // Reset with two beats in flight
    put(300, -300);
    put(-400, 400);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 0);
    check("mid_rst_y", 32'(y_o), 0);
    check("mid_rst_sat", 32'(sat_o), 0);
    check("mid_rst_alarm", 32'(alarm_o), 0);
    check("mid_rst_cnt", 32'(sat_cnt_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    put(1, 2);
    valid_i = 1'b0;
    check("post_rst_lat1", 32'(valid_o), 0);
    @(posedge clk); #1;
    check("post_rst_lat2", 32'(valid_o), 1);
    e = model(1, 2);
    check("post_rst_y", 32'(y_o), 32'(e.y));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
